// File: rtl/adam_mem_pkg.sv
// Shared types for the adam AXI-Lite RAM.
//   ram_state_t : transaction FSM states
//   RESP_OKAY   : the only response code this RAM ever returns
package adam_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_RESP,
    ST_WR_RESP,
    ST_PAUSED
  } ram_state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite bundle (AW, W, B, AR, R channels) with Master/Slave modports.
interface AXI_LITE #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport Master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport Slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/adam_mem_sp.sv
// Behavioural single-port synchronous RAM with per-byte write enables.
//   clk   : clock
//   en    : access enable (read and/or write this cycle)
//   we    : per-byte write enables
//   addr  : word index
//   wdata : write data
//   rdata : registered read data (old contents on a write cycle)
module adam_mem_sp #(
  parameter  int SIZE       = 4096,
  parameter  int DATA_WIDTH = 32,
  localparam int STRB_WIDTH = DATA_WIDTH / 8,
  localparam int DEPTH      = SIZE / STRB_WIDTH,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [STRB_WIDTH-1:0] we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
        if (we[b]) r_mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      r_rdata <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/adam_axil_ram.sv
// AXI-Lite slave RAM: one transaction at a time, read/write arbitration
// alternating on conflict, and a pause_req/pause_ack handshake that is only
// acknowledged once no transaction is in flight.
//   clk, rst  : clock, synchronous active-high reset
//   test      : DFT mode, no functional effect
//   pause_req : request to stop accepting transactions
//   pause_ack : pause granted (registered)
//   axil      : AXI-Lite slave port
module adam_axil_ram
  import adam_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SIZE       = 4096,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    test,
  input  logic    pause_req,
  output logic    pause_ack,
  AXI_LITE.Slave  axil
);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [STRB_WIDTH-1:0] strb_t;

  localparam int OFF_W = $clog2(STRB_WIDTH);
  localparam int TOP_W = $clog2(SIZE);
  localparam int IDX_W = TOP_W - OFF_W;

  ram_state_t r_state;
  logic       r_last_rd;
  logic       r_bvalid;
  logic       r_rvalid;
  logic       r_pause_ack;

  addr_t             w_awaddr;
  addr_t             w_araddr;
  logic              w_wr_elig;
  logic              w_rd_elig;
  logic              w_can_grant;
  logic              w_grant_wr;
  logic              w_grant_rd;
  logic [IDX_W-1:0]  w_ram_addr;
  strb_t             w_ram_we;
  data_t             w_ram_rdata;
  logic              w_unused;

  assign w_awaddr  = axil.awaddr;
  assign w_araddr  = axil.araddr;
  assign w_wr_elig = axil.awvalid & axil.wvalid;
  assign w_rd_elig = axil.arvalid;

  // Grants are combinational so the handshake lands in the same IDLE cycle;
  // on conflict the side that did not win last time gets priority.
  assign w_can_grant = (r_state == ST_IDLE) & ~pause_req;
  assign w_grant_wr  = w_can_grant & w_wr_elig & (~w_rd_elig | r_last_rd);
  assign w_grant_rd  = w_can_grant & w_rd_elig & (~w_wr_elig | ~r_last_rd);

  assign w_ram_addr = w_grant_wr ? w_awaddr[TOP_W-1:OFF_W] : w_araddr[TOP_W-1:OFF_W];
  assign w_ram_we   = w_grant_wr ? axil.wstrb : '0;

  adam_mem_sp #(
    .SIZE       (SIZE),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .en    (w_grant_wr | w_grant_rd),
    .we    (w_ram_we),
    .addr  (w_ram_addr),
    .wdata (axil.wdata),
    .rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_last_rd   <= 1'b1;
      r_bvalid    <= 1'b0;
      r_rvalid    <= 1'b0;
      r_pause_ack <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (pause_req) begin
            r_state     <= ST_PAUSED;
            r_pause_ack <= 1'b1;
          end else if (w_grant_wr) begin
            r_state   <= ST_WR_RESP;
            r_bvalid  <= 1'b1;
            r_last_rd <= 1'b0;
          end else if (w_grant_rd) begin
            r_state   <= ST_RD_RESP;
            r_rvalid  <= 1'b1;
            r_last_rd <= 1'b1;
          end
        end
        ST_WR_RESP: begin
          if (axil.bready) begin
            r_bvalid <= 1'b0;
            if (pause_req) begin
              r_state     <= ST_PAUSED;
              r_pause_ack <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_RD_RESP: begin
          if (axil.rready) begin
            r_rvalid <= 1'b0;
            if (pause_req) begin
              r_state     <= ST_PAUSED;
              r_pause_ack <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_PAUSED: begin
          if (!pause_req) begin
            r_state     <= ST_IDLE;
            r_pause_ack <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign axil.awready = w_grant_wr;
  assign axil.wready  = w_grant_wr;
  assign axil.arready = w_grant_rd;
  assign axil.bvalid  = r_bvalid;
  assign axil.bresp   = RESP_OKAY;
  assign axil.rvalid  = r_rvalid;
  assign axil.rresp   = RESP_OKAY;
  // RAM output register has no reset and also updates on writes, so it is
  // only exposed while a read response is outstanding.
  assign axil.rdata   = (r_state == ST_RD_RESP) ? w_ram_rdata : '0;
  assign pause_ack    = r_pause_ack;

  assign w_unused = ^{test, w_awaddr[ADDR_WIDTH-1:TOP_W], w_awaddr[OFF_W-1:0],
                      w_araddr[ADDR_WIDTH-1:TOP_W], w_araddr[OFF_W-1:0]};

endmodule

// File: tb/tb_adam_axil_ram.sv
module tb_adam_axil_ram;

  logic clk;
  logic rst;
  logic test;
  logic pause_req;
  logic pause_ack;

  int n_cmp;
  int n_err;

  AXI_LITE #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axil_if ();

  adam_axil_ram #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .SIZE       (4096)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .test      (test),
    .pause_req (pause_req),
    .pause_ack (pause_ack),
    .axil      (axil_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    axil_if.awaddr  = a;
    axil_if.wdata   = d;
    axil_if.wstrb   = s;
    axil_if.awvalid = 1'b1;
    axil_if.wvalid  = 1'b1;
    #1;
    chk1("wr_awready", axil_if.awready, 1'b1);
    chk1("wr_wready", axil_if.wready, 1'b1);
    tick();
    chk1("wr_bvalid", axil_if.bvalid, 1'b1);
    chkw("wr_bresp", {30'd0, axil_if.bresp}, 32'd0);
    axil_if.awvalid = 1'b0;
    axil_if.wvalid  = 1'b0;
    axil_if.bready  = 1'b1;
    tick();
    chk1("wr_bvalid_drop", axil_if.bvalid, 1'b0);
    axil_if.bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp);
    axil_if.araddr  = a;
    axil_if.arvalid = 1'b1;
    #1;
    chk1("rd_arready", axil_if.arready, 1'b1);
    tick();
    chk1("rd_rvalid", axil_if.rvalid, 1'b1);
    chkw("rd_rdata", axil_if.rdata, exp);
    chkw("rd_rresp", {30'd0, axil_if.rresp}, 32'd0);
    axil_if.arvalid = 1'b0;
    axil_if.rready  = 1'b1;
    tick();
    chk1("rd_rvalid_drop", axil_if.rvalid, 1'b0);
    axil_if.rready = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    test = 1'b0;
    pause_req = 1'b0;
    axil_if.awaddr  = '0;
    axil_if.awvalid = 1'b0;
    axil_if.wdata   = '0;
    axil_if.wstrb   = '0;
    axil_if.wvalid  = 1'b0;
    axil_if.bready  = 1'b0;
    axil_if.araddr  = '0;
    axil_if.arvalid = 1'b0;
    axil_if.rready  = 1'b0;
    tick();
    tick();

    // Reset state
    chk1("rst_awready", axil_if.awready, 1'b0);
    chk1("rst_wready", axil_if.wready, 1'b0);
    chk1("rst_arready", axil_if.arready, 1'b0);
    chk1("rst_bvalid", axil_if.bvalid, 1'b0);
    chk1("rst_rvalid", axil_if.rvalid, 1'b0);
    chk1("rst_pause_ack", pause_ack, 1'b0);
    chkw("rst_rdata", axil_if.rdata, 32'h0);
    rst = 1'b0;
    tick();

    // Conflict right after reset: write wins, then read wins
    axil_if.awaddr  = 32'h20;
    axil_if.wdata   = 32'hA5A5A5A5;
    axil_if.wstrb   = 4'hF;
    axil_if.awvalid = 1'b1;
    axil_if.wvalid  = 1'b1;
    axil_if.araddr  = 32'h20;
    axil_if.arvalid = 1'b1;
    #1;
    chk1("arb1_awready", axil_if.awready, 1'b1);
    chk1("arb1_arready", axil_if.arready, 1'b0);
    tick();
    chk1("arb1_bvalid", axil_if.bvalid, 1'b1);
    chk1("arb1_arready_busy", axil_if.arready, 1'b0);
    axil_if.awvalid = 1'b0;
    axil_if.wvalid  = 1'b0;
    axil_if.bready  = 1'b1;
    tick();
    axil_if.bready  = 1'b0;
    chk1("arb1_bvalid_drop", axil_if.bvalid, 1'b0);
    axil_if.awaddr  = 32'h24;
    axil_if.wdata   = 32'h5A5A5A5A;
    axil_if.awvalid = 1'b1;
    axil_if.wvalid  = 1'b1;
    #1;
    chk1("arb2_arready", axil_if.arready, 1'b1);
    chk1("arb2_awready", axil_if.awready, 1'b0);
    tick();
    chk1("arb2_rvalid", axil_if.rvalid, 1'b1);
    chkw("arb2_rdata", axil_if.rdata, 32'hA5A5A5A5);
    axil_if.arvalid = 1'b0;
    axil_if.rready  = 1'b1;
    tick();
    axil_if.rready  = 1'b0;
    chk1("arb3_awready", axil_if.awready, 1'b1);
    tick();
    chk1("arb3_bvalid", axil_if.bvalid, 1'b1);
    axil_if.awvalid = 1'b0;
    axil_if.wvalid  = 1'b0;
    axil_if.bready  = 1'b1;
    tick();
    axil_if.bready  = 1'b0;
    do_read(32'h24, 32'h5A5A5A5A);

    // Basic full-word write/read
    do_write(32'h10, 32'hDEADBEEF, 4'hF);
    do_read(32'h10, 32'hDEADBEEF);

    // Byte strobes and aliasing
    do_write(32'h8, 32'hFFFFFFFF, 4'hF);
    do_write(32'h8, 32'h11223344, 4'b0101);
    do_read(32'h8, 32'hFF22FF44);
    do_read(32'h8 + 32'd4096, 32'hFF22FF44);
    do_write(32'h8, 32'h00000000, 4'h0);
    do_read(32'hB, 32'hFF22FF44);

    // Read response back-pressure
    axil_if.araddr  = 32'h10;
    axil_if.arvalid = 1'b1;
    tick();
    axil_if.araddr  = 32'h8;
    for (int i = 0; i < 5; i++) begin
      chk1("bp_rvalid", axil_if.rvalid, 1'b1);
      chkw("bp_rdata", axil_if.rdata, 32'hDEADBEEF);
      chk1("bp_arready", axil_if.arready, 1'b0);
      tick();
    end
    axil_if.rready = 1'b1;
    tick();
    axil_if.rready = 1'b0;
    chk1("bp_rvalid_drop", axil_if.rvalid, 1'b0);
    chk1("bp_arready_idle", axil_if.arready, 1'b1);
    axil_if.arvalid = 1'b0;
    tick();

    // Pause while a read response is stalled
    axil_if.araddr  = 32'h8;
    axil_if.arvalid = 1'b1;
    tick();
    axil_if.arvalid = 1'b0;
    pause_req = 1'b1;
    tick();
    chk1("pz_ack_busy1", pause_ack, 1'b0);
    tick();
    chk1("pz_ack_busy2", pause_ack, 1'b0);
    chk1("pz_rvalid_held", axil_if.rvalid, 1'b1);
    axil_if.rready = 1'b1;
    tick();
    axil_if.rready = 1'b0;
    chk1("pz_ack_up", pause_ack, 1'b1);
    chk1("pz_rvalid_drop", axil_if.rvalid, 1'b0);
    axil_if.awaddr  = 32'h10;
    axil_if.wdata   = 32'h0;
    axil_if.wstrb   = 4'hF;
    axil_if.awvalid = 1'b1;
    axil_if.wvalid  = 1'b1;
    axil_if.araddr  = 32'h10;
    axil_if.arvalid = 1'b1;
    #1;
    chk1("pz_arready", axil_if.arready, 1'b0);
    chk1("pz_awready", axil_if.awready, 1'b0);
    tick();
    tick();
    chk1("pz_ack_hold", pause_ack, 1'b1);
    chk1("pz_awready2", axil_if.awready, 1'b0);
    axil_if.awvalid = 1'b0;
    axil_if.wvalid  = 1'b0;
    pause_req = 1'b0;
    #1;
    chk1("pz_arready_release", axil_if.arready, 1'b0);
    tick();
    chk1("pz_ack_down", pause_ack, 1'b0);
    chk1("pz_arready_resume", axil_if.arready, 1'b1);
    tick();
    chk1("pz_q_rvalid", axil_if.rvalid, 1'b1);
    chkw("pz_q_rdata", axil_if.rdata, 32'hDEADBEEF);
    axil_if.arvalid = 1'b0;
    axil_if.rready  = 1'b1;
    tick();
    axil_if.rready  = 1'b0;

    // Reset during a stalled write response
    axil_if.awaddr  = 32'h30;
    axil_if.wdata   = 32'hCAFEF00D;
    axil_if.wstrb   = 4'hF;
    axil_if.awvalid = 1'b1;
    axil_if.wvalid  = 1'b1;
    tick();
    chk1("rs_bvalid", axil_if.bvalid, 1'b1);
    axil_if.awvalid = 1'b0;
    axil_if.wvalid  = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("rs_bvalid_drop", axil_if.bvalid, 1'b0);
    chk1("rs_pause_ack", pause_ack, 1'b0);
    tick();
    do_read(32'h30, 32'hCAFEF00D);
    do_read(32'h10, 32'hDEADBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
